// File: rtl/collision_scheduler.sv
// collision_scheduler: shares one map/character collision detector across all
// enemy slots, one detector pass per live enemy on every game tick.
module collision_scheduler #(
  parameter int NUM_ENEMIES = 4,
  parameter int TIMEOUT     = 31
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [NUM_ENEMIES-1:0]   enemy_alive,
  input  logic [9*NUM_ENEMIES-1:0] enemy_x_bus,
  input  logic [8*NUM_ENEMIES-1:0] enemy_y_bus,
  input  logic [3*NUM_ENEMIES-1:0] enemy_dir_bus,
  output logic                     det_init,
  output logic                     det_enable,
  output logic [8:0]               det_enemy_x,
  output logic [7:0]               det_enemy_y,
  output logic [2:0]               det_dir_enemy,
  input  logic                     det_c_map,
  input  logic                     det_e_map,
  input  logic                     det_c_e,
  input  logic                     det_e_hit,
  input  logic                     det_done,
  output logic                     c_map_collision,
  output logic [NUM_ENEMIES-1:0]   e_map_collision,
  output logic [NUM_ENEMIES-1:0]   c_e_collision,
  output logic [NUM_ENEMIES-1:0]   e_hit,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);
  localparam int IW = $clog2(NUM_ENEMIES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_END = IW'(NUM_ENEMIES);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_INIT, S_WAIT, S_LATCH, S_FINISH
  } state_t;

  state_t                   state_reg, state_next;
  logic [IW-1:0]            idx_reg, idx_next;
  logic [TW-1:0]            timer_reg, timer_next;
  logic                     forced_reg, forced_next;
  logic [NUM_ENEMIES-1:0]   alive_snap_reg, alive_snap_next;
  logic [9*NUM_ENEMIES-1:0] x_snap_reg, x_snap_next;
  logic [8*NUM_ENEMIES-1:0] y_snap_reg, y_snap_next;
  logic [3*NUM_ENEMIES-1:0] dir_snap_reg, dir_snap_next;
  logic                     c_map_reg, c_map_next;
  logic [NUM_ENEMIES-1:0]   e_map_reg, e_map_next;
  logic [NUM_ENEMIES-1:0]   c_e_reg, c_e_next;
  logic [NUM_ENEMIES-1:0]   e_hit_reg, e_hit_next;
  logic                     timeout_reg, timeout_next;

  logic                     slot_alive;
  logic                     slot_live;
  logic [NUM_ENEMIES-1:0]   latch_mask;

  // Detector fields come from the snapshot; idx only moves on the way back to SELECT.
  always_comb begin
    slot_alive    = 1'b0;
    det_enemy_x   = '0;
    det_enemy_y   = '0;
    det_dir_enemy = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (idx_reg == IW'(i)) begin
        slot_alive    = alive_snap_reg[i];
        det_enemy_x   = x_snap_reg[9*i +: 9];
        det_enemy_y   = y_snap_reg[8*i +: 8];
        det_dir_enemy = dir_snap_reg[3*i +: 3];
      end
    end
  end

  // An all-dead snapshot still needs one character-only pass on slot 0.
  assign slot_live = slot_alive || (forced_reg && (idx_reg == '0));

  generate
    for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_slot
      assign latch_mask[gi] = (state_reg == S_LATCH) && !forced_reg && (idx_reg == IW'(gi));
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    timer_next      = timer_reg;
    forced_next     = forced_reg;
    alive_snap_next = alive_snap_reg;
    x_snap_next     = x_snap_reg;
    y_snap_next     = y_snap_reg;
    dir_snap_next   = dir_snap_reg;
    c_map_next      = c_map_reg;
    e_map_next      = (e_map_reg & ~latch_mask) | (latch_mask & {NUM_ENEMIES{det_e_map}});
    c_e_next        = (c_e_reg & ~latch_mask) | (latch_mask & {NUM_ENEMIES{det_c_e}});
    e_hit_next      = (e_hit_reg & ~latch_mask) | (latch_mask & {NUM_ENEMIES{det_e_hit}});
    timeout_next    = timeout_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next      = S_SELECT;
          idx_next        = '0;
          alive_snap_next = enemy_alive;
          x_snap_next     = enemy_x_bus;
          y_snap_next     = enemy_y_bus;
          dir_snap_next   = enemy_dir_bus;
          forced_next     = (enemy_alive == '0);
          c_map_next      = 1'b0;
          e_map_next      = '0;
          c_e_next        = '0;
          e_hit_next      = '0;
          timeout_next    = 1'b0;
        end
      end
      S_SELECT: begin
        if (idx_reg == IDX_END) begin
          state_next = S_FINISH;
        end else if (slot_live) begin
          state_next = S_INIT;
        end else begin
          idx_next = idx_reg + IW'(1);
        end
      end
      S_INIT: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_next = timer_reg + TW'(1);
        if (det_done) begin
          state_next = S_LATCH;
        end else if (timer_next == TW'(TIMEOUT)) begin
          timeout_next = 1'b1;
          idx_next     = idx_reg + IW'(1);
          state_next   = S_SELECT;
        end
      end
      S_LATCH: begin
        c_map_next = c_map_reg | det_c_map;
        idx_next   = idx_reg + IW'(1);
        state_next = S_SELECT;
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      timer_reg      <= '0;
      forced_reg     <= 1'b0;
      alive_snap_reg <= '0;
      x_snap_reg     <= '0;
      y_snap_reg     <= '0;
      dir_snap_reg   <= '0;
      c_map_reg      <= 1'b0;
      e_map_reg      <= '0;
      c_e_reg        <= '0;
      e_hit_reg      <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      timer_reg      <= timer_next;
      forced_reg     <= forced_next;
      alive_snap_reg <= alive_snap_next;
      x_snap_reg     <= x_snap_next;
      y_snap_reg     <= y_snap_next;
      dir_snap_reg   <= dir_snap_next;
      c_map_reg      <= c_map_next;
      e_map_reg      <= e_map_next;
      c_e_reg        <= c_e_next;
      e_hit_reg      <= e_hit_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign det_init        = (state_reg == S_INIT);
  assign det_enable      = (state_reg == S_WAIT) || (state_reg == S_LATCH);
  assign busy            = (state_reg != S_IDLE);
  assign done            = (state_reg == S_FINISH);
  assign c_map_collision = c_map_reg;
  assign e_map_collision = e_map_reg;
  assign c_e_collision   = c_e_reg;
  assign e_hit           = e_hit_reg;
  assign timeout_err     = timeout_reg;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: a behavioural detector plus a sweep-level
// reference model predicting timing, pass order and latched results.
module tb_collision_scheduler;
  localparam int N  = 4;
  localparam int TO = 31;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   enemy_alive = '0;
  logic [9*N-1:0] enemy_x_bus = '0;
  logic [8*N-1:0] enemy_y_bus = '0;
  logic [3*N-1:0] enemy_dir_bus = '0;
  logic           det_init, det_enable;
  logic [8:0]     det_enemy_x;
  logic [7:0]     det_enemy_y;
  logic [2:0]     det_dir_enemy;
  logic           det_c_map, det_e_map, det_c_e, det_e_hit, det_done;
  logic           c_map_collision;
  logic [N-1:0]   e_map_collision, c_e_collision, e_hit;
  logic           busy, done, timeout_err;

  int checks = 0;
  int errors = 0;

  // detector behaviour and per-sweep configuration
  logic [N-1:0] cfg_alive, resp_c_map, resp_e_map, resp_c_e, resp_e_hit;
  int           resp_d [N];
  logic [8:0]   snap_x [N];
  logic [7:0]   snap_y [N];
  logic [2:0]   snap_dir [N];

  // reference model output: {timeout_err, c_map, e_map, c_e, e_hit}
  int             exp_done_cycle, exp_inits, exp_enable;
  int             exp_order [$];
  logic [3*N+1:0] exp_res;

  // observations of the last sweep
  int             obs_done_cycle, obs_inits, obs_bad, obs_dones, obs_busy_bad, obs_enable;
  logic           obs_busy_after;
  logic [3*N+1:0] obs_clear;
  logic [37:0]    obs_rst_vec;

  collision_scheduler #(.NUM_ENEMIES(N), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .enemy_alive(enemy_alive), .enemy_x_bus(enemy_x_bus),
    .enemy_y_bus(enemy_y_bus), .enemy_dir_bus(enemy_dir_bus),
    .det_init(det_init), .det_enable(det_enable),
    .det_enemy_x(det_enemy_x), .det_enemy_y(det_enemy_y), .det_dir_enemy(det_dir_enemy),
    .det_c_map(det_c_map), .det_e_map(det_e_map), .det_c_e(det_c_e),
    .det_e_hit(det_e_hit), .det_done(det_done),
    .c_map_collision(c_map_collision), .e_map_collision(e_map_collision),
    .c_e_collision(c_e_collision), .e_hit(e_hit),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  initial forever #5 clock = ~clock;

  // Detector: raises done D cycles after its init cycle, then holds its results.
  initial begin
    int  rem;
    int  slot;
    bit  active;
    det_done = 1'b0;
    {det_c_map, det_e_map, det_c_e, det_e_hit} = 4'b0;
    active = 1'b0;
    rem = 0;
    slot = 0;
    forever begin
      @(posedge clock);
      #1;
      det_done = 1'b0;
      if (det_init) begin
        slot   = int'(det_enemy_x[1:0]);
        rem    = resp_d[slot];
        active = 1'b1;
        {det_c_map, det_e_map, det_c_e, det_e_hit} = 4'($urandom);
      end else if (active) begin
        rem--;
        if (rem == 0) begin
          det_done  = 1'b1;
          det_c_map = resp_c_map[slot];
          det_e_map = resp_e_map[slot];
          det_c_e   = resp_c_e[slot];
          det_e_hit = resp_e_hit[slot];
          active    = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [3*N+1:0] cur_res();
    return {timeout_err, c_map_collision, e_map_collision, c_e_collision, e_hit};
  endfunction

  function automatic logic [37:0] out_vec();
    return {det_init, det_enable, det_enemy_x, det_enemy_y, det_dir_enemy,
            c_map_collision, e_map_collision, c_e_collision, e_hit, busy, done, timeout_err};
  endfunction

  // Sweep-level prediction straight from the pass rules and cycle costs.
  task automatic compute_expect();
    bit           forced;
    int           t;
    logic         to_err, cmap;
    logic [N-1:0] em, ce, eh;
    forced = (cfg_alive == '0);
    t = 0; to_err = 1'b0; cmap = 1'b0; em = '0; ce = '0; eh = '0;
    exp_enable = 0;
    exp_order.delete();
    for (int i = 0; i < N; i++) begin
      if (cfg_alive[i] || (forced && i == 0)) begin
        exp_order.push_back(i);
        if (resp_d[i] <= TO) begin
          t += 3 + resp_d[i];
          exp_enable += resp_d[i] + 1;
          cmap |= resp_c_map[i];
          if (!forced) begin
            em[i] = resp_e_map[i];
            ce[i] = resp_c_e[i];
            eh[i] = resp_e_hit[i];
          end
        end else begin
          t += 2 + TO;
          exp_enable += TO;
          to_err = 1'b1;
        end
      end else begin
        t += 1;
      end
    end
    exp_done_cycle = t + 2;
    exp_inits = exp_order.size();
    exp_res = {to_err, cmap, em, ce, eh};
  endtask

  task automatic randomize_responses(input int dmax);
    resp_c_map = N'($urandom); resp_e_map = N'($urandom);
    resp_c_e   = N'($urandom); resp_e_hit = N'($urandom);
    for (int i = 0; i < N; i++) resp_d[i] = int'($urandom_range(1, dmax));
  endtask

  // Drives one sweep (cycle 0 = start accepted) and records what the DUT did.
  task automatic run_sweep(input int pulse_at, input int reset_at);
    int          n, pass;
    logic [19:0] cur;
    obs_done_cycle = -1; obs_inits = 0; obs_bad = 0; obs_dones = 0;
    obs_busy_bad = 0; obs_enable = 0; obs_busy_after = 1'b0; obs_clear = '1;
    pass = 0; cur = '0;
    for (int i = 0; i < N; i++) begin
      snap_x[i]   = {7'($urandom), 2'(i)};
      snap_y[i]   = 8'($urandom);
      snap_dir[i] = 3'($urandom);
      enemy_x_bus[9*i +: 9]   = snap_x[i];
      enemy_y_bus[8*i +: 8]   = snap_y[i];
      enemy_dir_bus[3*i +: 3] = snap_dir[i];
    end
    enemy_alive = cfg_alive;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    enemy_x_bus   = (9*N)'({$urandom, $urandom});
    enemy_y_bus   = (8*N)'($urandom);
    enemy_dir_bus = (3*N)'($urandom);
    enemy_alive   = N'($urandom);
    n = 1;
    while (n < 400) begin
      @(negedge clock);
      if (n == 1) obs_clear = cur_res();
      if (!busy) obs_busy_bad++;
      if (det_enable) obs_enable++;
      if (det_init) begin
        obs_inits++;
        cur = {det_enemy_x, det_enemy_y, det_dir_enemy};
        if (pass >= exp_order.size() ||
            cur !== {snap_x[exp_order[pass]], snap_y[exp_order[pass]], snap_dir[exp_order[pass]]})
          obs_bad++;
        pass++;
      end
      if (det_enable && {det_enemy_x, det_enemy_y, det_dir_enemy} !== cur) obs_bad++;
      if (n == reset_at) begin
        resetn = 1'b0;
        #1;
        obs_rst_vec = out_vec();
        @(negedge clock);
        resetn = 1'b1;
        return;
      end
      start = (n == pulse_at);
      if (done) begin
        obs_dones++;
        obs_done_cycle = n;
        break;
      end
      @(posedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (busy) obs_busy_after = 1'b1;
      if (done) obs_dones++;
    end
    $display("sweep alive=%b done_cycle=%0d inits=%0d results=%b", cfg_alive,
             obs_done_cycle, obs_inits, cur_res());
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL idle_outputs: got %h expected 0", out_vec());
    end
  endtask

  task automatic test_two_live();
    cfg_alive = 4'b0101;
    randomize_responses(16);
    for (int i = 0; i < N; i++) resp_d[i] = 16;
    resp_e_map = 4'b0100;
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (e_map_collision !== 4'b0100) begin
      errors++; $display("FAIL two_live_e_map: got %b expected 0100", e_map_collision);
    end
    checks++;
    if (obs_done_cycle !== 42) begin
      errors++; $display("FAIL two_live_done_cycle: got %0d expected 42", obs_done_cycle);
    end
    checks++;
    if (obs_inits !== 2) begin
      errors++; $display("FAIL two_live_inits: got %0d expected 2", obs_inits);
    end
    checks++;
    if (cur_res() !== exp_res) begin
      errors++; $display("FAIL two_live_results: got %b expected %b", cur_res(), exp_res);
    end
    checks++;
    if (obs_busy_after !== 1'b0 || obs_busy_bad !== 0 || obs_dones !== 1) begin
      errors++; $display("FAIL two_live_busy_done: got busy_after=%b busy_gaps=%0d dones=%0d expected 0 0 1",
                         obs_busy_after, obs_busy_bad, obs_dones);
    end
    checks++;
    if (obs_enable !== exp_enable || obs_bad !== 0) begin
      errors++; $display("FAIL two_live_det_drive: got enable=%0d field_errs=%0d expected %0d 0",
                         obs_enable, obs_bad, exp_enable);
    end
  endtask

  task automatic test_no_alive();
    cfg_alive = '0;
    randomize_responses(12);
    resp_c_map[0] = 1'b1;
    resp_e_map = '1; resp_c_e = '1; resp_e_hit = '1;
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (cur_res() !== {1'b0, 1'b1, {(3*N){1'b0}}}) begin
      errors++; $display("FAIL no_alive_results: got %b expected c_map only", cur_res());
    end
    checks++;
    if (obs_inits !== 1 || obs_done_cycle !== exp_done_cycle || obs_dones !== 1) begin
      errors++; $display("FAIL no_alive_pass: got inits=%0d done=%0d dones=%0d expected 1 %0d 1",
                         obs_inits, obs_done_cycle, obs_dones, exp_done_cycle);
    end
  endtask

  task automatic test_timeout();
    cfg_alive = 4'b1111;
    randomize_responses(10);
    resp_d[1] = 1000;
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (timeout_err !== 1'b1 || e_map_collision[1] !== 1'b0 || c_e_collision[1] !== 1'b0 || e_hit[1] !== 1'b0) begin
      errors++; $display("FAIL timeout_slot1: got %b expected err=1 slot1 bits 0", cur_res());
    end
    checks++;
    if (cur_res() !== exp_res || obs_done_cycle !== exp_done_cycle) begin
      errors++; $display("FAIL timeout_sweep: got %b at %0d expected %b at %0d",
                         cur_res(), obs_done_cycle, exp_res, exp_done_cycle);
    end
    // done arriving on the last allowed WAIT cycle wins; one cycle later is a timeout
    cfg_alive = 4'b0101;
    randomize_responses(10);
    resp_d[0] = TO;
    resp_d[2] = TO + 1;
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (cur_res() !== exp_res || obs_done_cycle !== exp_done_cycle) begin
      errors++; $display("FAIL timeout_boundary: got %b at %0d expected %b at %0d",
                         cur_res(), obs_done_cycle, exp_res, exp_done_cycle);
    end
  endtask

  task automatic test_restart_ignored();
    cfg_alive = 4'b1011;
    randomize_responses(14);
    compute_expect();
    run_sweep(5, -1);
    checks++;
    if (obs_done_cycle !== exp_done_cycle || obs_dones !== 1 || obs_busy_after !== 1'b0) begin
      errors++; $display("FAIL restart_ignored: got done=%0d dones=%0d busy_after=%b expected %0d 1 0",
                         obs_done_cycle, obs_dones, obs_busy_after, exp_done_cycle);
    end
    checks++;
    if (obs_bad !== 0 || cur_res() !== exp_res) begin
      errors++; $display("FAIL snapshot_fields: got field_errs=%0d res=%b expected 0 %b",
                         obs_bad, cur_res(), exp_res);
    end
    // start coinciding with FINISH is dropped as well
    compute_expect();
    run_sweep(exp_done_cycle, -1);
    checks++;
    if (obs_busy_after !== 1'b0 || obs_dones !== 1) begin
      errors++; $display("FAIL finish_start: got busy_after=%b dones=%0d expected 0 1",
                         obs_busy_after, obs_dones);
    end
  endtask

  task automatic test_hold_and_clear();
    cfg_alive = 4'b1111;
    randomize_responses(10);
    resp_c_e = 4'b1001;
    resp_e_hit = 4'b1001;
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (c_e_collision !== 4'b1001 || e_hit !== 4'b1001) begin
      errors++; $display("FAIL hit_vectors: got c_e=%b e_hit=%b expected 1001 1001", c_e_collision, e_hit);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (cur_res() !== exp_res) begin
      errors++; $display("FAIL results_hold: got %b expected %b", cur_res(), exp_res);
    end
    resp_c_map = '0; resp_e_map = '0; resp_c_e = '0; resp_e_hit = '0;
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (obs_clear !== '0 || cur_res() !== '0) begin
      errors++; $display("FAIL results_clear: got at_start=%b final=%b expected 0 0", obs_clear, cur_res());
    end
  endtask

  task automatic test_reset_mid_wait();
    cfg_alive = 4'b1111;
    randomize_responses(16);
    for (int i = 0; i < N; i++) resp_d[i] = 16;
    compute_expect();
    run_sweep(-1, 10);
    checks++;
    if (obs_rst_vec !== '0) begin
      errors++; $display("FAIL reset_mid_wait: got %h expected 0", obs_rst_vec);
    end
    repeat (2) @(negedge clock);
    cfg_alive = N'($urandom);
    randomize_responses(20);
    compute_expect();
    run_sweep(-1, -1);
    checks++;
    if (cur_res() !== exp_res || obs_done_cycle !== exp_done_cycle || obs_inits !== exp_inits) begin
      errors++; $display("FAIL after_reset_sweep: got %b at %0d inits=%0d expected %b at %0d inits=%0d",
                         cur_res(), obs_done_cycle, obs_inits, exp_res, exp_done_cycle, exp_inits);
    end
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 16; k++) begin
      cfg_alive = (k % 5 == 4) ? '0 : N'($urandom);
      randomize_responses(20);
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) resp_d[i] = TO + 1 + int'($urandom_range(0, 8));
        else if (r == 1) resp_d[i] = TO;
      end
      compute_expect();
      run_sweep(-1, -1);
      checks++;
      if (cur_res() !== exp_res) begin
        errors++; $display("FAIL random_results[%0d]: got %b expected %b", k, cur_res(), exp_res);
      end
      checks++;
      if (obs_done_cycle !== exp_done_cycle || obs_inits !== exp_inits || obs_enable !== exp_enable) begin
        errors++; $display("FAIL random_timing[%0d]: got done=%0d inits=%0d en=%0d expected %0d %0d %0d",
                           k, obs_done_cycle, obs_inits, obs_enable, exp_done_cycle, exp_inits, exp_enable);
      end
      checks++;
      if (obs_bad !== 0 || obs_clear !== '0 || obs_dones !== 1) begin
        errors++; $display("FAIL random_drive[%0d]: got field_errs=%0d clear=%b dones=%0d expected 0 0 1",
                           k, obs_bad, obs_clear, obs_dones);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) resp_d[i] = 1;
    resp_c_map = '0; resp_e_map = '0; resp_c_e = '0; resp_e_hit = '0;
    cfg_alive = '0;
    test_reset();
    test_two_live();
    test_no_alive();
    test_timeout();
    test_restart_ignored();
    test_hold_and_clear();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
